// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 matrix keypad, debounces the closed contact, and reports
//   one key event per physical press to the calculator controller.
//
//   Optional auto-repeat is enabled by defining the macro KEYPAD_REPEAT_EN.
//   Without it no repeat logic exists and each press yields one key_valid.
//
// Ports
//   clock     in   1  system clock
//   reset_n   in   1  synchronous, active-low reset
//   rows      in   4  keypad rows, active-low, asynchronous to clock
//   cols      out  4  column drive, active-low, exactly one bit low
//   key_code  out  4  accepted key, row*4+col, held until the next key
//   key_valid out  1  one-cycle pulse marking a key event
//   key_held  out  1  high from accepted press until accepted release
module keypad_scanner #(
    parameter int unsigned SETTLE_CYCLES   = 50,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    // One counter serves settle, press-debounce and release-debounce,
    // since only one of them is ever running.
    localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > SETTLE_CYCLES) ?
                                      DEBOUNCE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("SETTLE_CYCLES must be >= 3");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 2");
    end
    // A repeat interval of 1 would make key_valid high on adjacent cycles.
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
    end

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [3:0]       rows_meta_q, rows_meta_d;
    logic [3:0]       srows_q,     srows_d;
    logic [1:0]       col_q,       col_d;
    logic [1:0]       cand_row_q,  cand_row_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [3:0]       key_code_q,  key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q,  key_held_d;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                      REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt_q,   rpt_cnt_d;
    logic             rpt_first_q, rpt_first_d;
`endif

    logic       any_low;
    logic [1:0] active_row;
    logic       cand_low;

    // Fixed priority: the lowest-numbered low row wins.
    always_comb begin
        any_low    = 1'b0;
        active_row = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!srows_q[i] && !any_low) begin
                active_row = 2'(i);
                any_low    = 1'b1;
            end
        end
        cand_low = ~srows_q[cand_row_q];
    end

    // State register (all flops, synchronous active-low reset)
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= SCAN;
            rows_meta_q <= '1;
            srows_q     <= '1;
            col_q       <= '0;
            cand_row_q  <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            rows_meta_q <= rows_meta_d;
            srows_q     <= srows_d;
            col_q       <= col_d;
            cand_row_q  <= cand_row_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
`endif
        end
    end

    // Next-state and datapath
    always_comb begin
        rows_meta_d = rows;
        srows_d     = rows_meta_q;
        state_d     = state_q;
        col_d       = col_q;
        cand_row_d  = cand_row_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b1;
`endif

        case (state_q)
            SCAN: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (any_low) begin
                        cand_row_d = active_row;
                        state_d    = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DEBOUNCE: begin
                if (any_low && (active_row == cand_row_q)) begin
                    if (cnt_q == DEB_LAST) begin
                        cnt_d       = '0;
                        key_code_d  = {cand_row_q, col_q};
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        state_d     = HELD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // Bounce or a different row: rescan this same column.
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end

            HELD: begin
                // Only the candidate row is watched; other keys are ignored.
                if (cand_low) begin
                    cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
                    // First repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
                    if (rpt_cnt_q == (rpt_first_q ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
                        key_valid_d = 1'b1;
                        rpt_cnt_d   = '0;
                        rpt_first_d = 1'b0;
                    end else begin
                        rpt_cnt_d   = rpt_cnt_q + 1'b1;
                        rpt_first_d = rpt_first_q;
                    end
`endif
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d      = '0;
                    key_held_d = 1'b0;
                    col_d      = col_q + 2'd1;
                    state_d    = SCAN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = SCAN;
            end
        endcase
    end

    // Outputs
    always_comb begin
        cols        = '1;
        cols[col_q] = 1'b0;
        key_code    = key_code_q;
        key_valid   = key_valid_q;
        key_held    = key_held_q;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int SETTLE  = 4;
    localparam int DEB     = 8;
    localparam int RDELAY  = 20;
    localparam int RPERIOD = 10;
`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_PULSES = 5;
`else
    localparam int EXP_PULSES = 1;
`endif

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // Pressed-key matrix, index row*4+col
    logic [15:0] keys = '0;

    int checks      = 0;
    int errors      = 0;
    int cycle       = 0;
    int valid_count = 0;
    logic [3:0] exp_q[$];
    int         stamps[$];

    always #5 clock = ~clock;

    // Keypad model: a pressed key pulls its row low while its column is driven
    always_comb begin
        rows = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    keypad_scanner #(
        .SETTLE_CYCLES  (SETTLE),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDELAY),
        .REPEAT_PERIOD  (RPERIOD)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .rows     (rows),
        .cols     (cols),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // Monitor: pops the scoreboard on every key_valid
    initial begin
        logic prev_valid;
        logic [3:0] exp;
        prev_valid = 1'b0;
        forever begin
            @(negedge clock);
            cycle++;
            checks++;
            if ($countones(~cols) != 1) begin
                errors++;
                $display("FAIL cols_onehot: got %b required exactly one low bit", cols);
            end
            if (key_valid === 1'b1) begin
                valid_count++;
                stamps.push_back(cycle);
                checks++;
                if (prev_valid) begin
                    errors++;
                    $display("FAIL valid_consecutive: got key_valid high two cycles running, required single pulse");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got key_valid with key_code=%0d, required none", key_code);
                end else begin
                    exp = exp_q.pop_front();
                    if (key_code !== exp) begin
                        errors++;
                        $display("FAIL key_code: got %0d required %0d", key_code, exp);
                    end
                end
            end
            prev_valid = key_valid;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_held(input logic lvl, input int limit, output int n);
        n = 0;
        while (key_held !== lvl && n < limit) begin
            @(negedge clock);
            n++;
        end
        check("wait_held", {31'd0, key_held}, {31'd0, lvl});
    endtask

    // Called right after reset release: column changes every SETTLE cycles
    task automatic check_walk(input int n);
        logic [3:0] e;
        int col;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            col = ((i + 1) / SETTLE) % 4;
            e = 4'b0001;
            e = ~(e << col);
            check("walk", {28'd0, cols}, {28'd0, e});
        end
    endtask

    task automatic bounce_test(input int idx);
        int v0;
        int n;
        v0 = valid_count;
        for (int i = 0; i < 40; i++) begin
            keys[idx] = ((i / 3) % 2) == 0;
            tick(1);
        end
        check("bounce_quiet", valid_count - v0, 0);
        keys[idx] = 1'b1;
        exp_q.push_back(4'(idx));
        wait_held(1'b1, 200, n);
        tick(5);
        keys[idx] = 1'b0;
        wait_held(1'b0, 40, n);
        check("bounce_count", valid_count - v0, 1);
    endtask

    initial begin
        int n;
        int v0;
        int s0;

        // Reset
        reset_n = 1'b0;
        keys    = '0;
        tick(3);
        check("rst_cols", {28'd0, cols}, 32'hE);
        check("rst_valid", {31'd0, key_valid}, 0);
        check("rst_held", {31'd0, key_held}, 0);
        check("rst_code", {28'd0, key_code}, 0);
        reset_n = 1'b1;
        check_walk(16);

        // Clean press: row 2, col 1 -> 9
        keys[9] = 1'b1;
        exp_q.push_back(4'd9);
        wait_held(1'b1, 200, n);
        tick(20);
        check("clean_held", {31'd0, key_held}, 1);
        check("clean_code", {28'd0, key_code}, 9);
        keys[9] = 1'b0;
        wait_held(1'b0, 40, n);
        check("release_cycles", n, 10);
        check("resume_col", {28'd0, cols}, 32'hB);

        // Bounce on row 0 col 3 (code 3) and on row 3 col 0 (code 12)
        bounce_test(3);
        bounce_test(12);

        // Two keys in col 0: row 1 wins; extra key during HELD ignored
        v0 = valid_count;
        keys[4]  = 1'b1;
        keys[12] = 1'b1;
        exp_q.push_back(4'd4);
        wait_held(1'b1, 200, n);
        keys[0] = 1'b1;
        tick(20);
        check("two_held", {31'd0, key_held}, 1);
        check("two_code", {28'd0, key_code}, 4);
        check("two_count", valid_count - v0, 1);
        keys = '0;
        wait_held(1'b0, 40, n);

        // Reset at debounce count 5
        v0 = valid_count;
        reset_n = 1'b0;
        keys[0] = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(9);
        reset_n = 1'b0;
        tick(3);
        check("midrst_cols", {28'd0, cols}, 32'hE);
        check("midrst_held", {31'd0, key_held}, 0);
        check("midrst_valid", {31'd0, key_valid}, 0);
        check("midrst_code", {28'd0, key_code}, 0);
        keys = '0;
        reset_n = 1'b1;
        check_walk(8);
        check("midrst_count", valid_count - v0, 0);

        // Key 6 held 55 cycles after acceptance
        v0 = valid_count;
        s0 = stamps.size();
        for (int i = 0; i < EXP_PULSES; i++) exp_q.push_back(4'd6);
        keys[6] = 1'b1;
        wait_held(1'b1, 200, n);
        tick(55);
        keys[6] = 1'b0;
        wait_held(1'b0, 40, n);
        check("repeat_count", valid_count - v0, EXP_PULSES);
`ifdef KEYPAD_REPEAT_EN
        if (stamps.size() >= s0 + 5) begin
            check("repeat_first", stamps[s0+1] - stamps[s0], RDELAY);
            for (int i = 2; i < 5; i++)
                check("repeat_period", stamps[s0+i] - stamps[s0+i-1], RPERIOD);
        end else begin
            check("repeat_stamps", stamps.size() - s0, 5);
        end
`else
        check("repeat_stamps", stamps.size() - s0, 1);
`endif

        tick(5);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
